// File: rtl/score_ctrl.sv
// score_ctrl: end-of-game score bookkeeping.
// A finished game is checked against the player's personal best, which is
// held in an external score RAM with a registered read. The best is
// rewritten when the new score beats it. The global top score and its
// owner ID are kept in registers here.
// Optional feature: define SCORE_CLEAR_EN to let clearReq wipe the RAM and
// the top score. Without it, clearReq is ignored.
//
// Handshake: gameOver and clearReq are one-shot requests sampled only while
// busy=0 (IDLE). A request seen while busy=1 is dropped, not queued. Each
// accepted request produces exactly one done pulse, and newBest/newTop are
// valid in the done cycle.
module score_ctrl #(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gameOver,
   input  logic              isGuest,
   input  logic [ADDR_W-1:0] userID,
   input  logic [3:0]        scoreTens,
   input  logic [3:0]        scoreOnes,
   input  logic              clearReq,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic [ADDR_W-1:0] topIntID,
   output logic [3:0]        topTens,
   output logic [3:0]        topOnes,
   output logic              busy,
   output logic              done,
   output logic              newBest,
   output logic              newTop,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CMP  = 3'd2,
      WR   = 3'd3,
      TOP  = 3'd4,
      DONE = 3'd5,
      CLR  = 3'd6
   } state_t;

   state_t            state, next_state;
   logic [ADDR_W-1:0] uid_q;
   logic [7:0]        score_q;
   logic [ADDR_W-1:0] top_id_q;
   logic [3:0]        top_tens_q, top_ones_q;
   logic              best_q, top_q;
   logic [ADDR_W-1:0] clr_cnt;
   logic              clr_go;
   logic              bad_game;

`ifdef SCORE_CLEAR_EN
   assign clr_go = clearReq;
`else
   // The clear request is accepted on the port but has no effect.
   logic unused_clear;
   assign unused_clear = clearReq;
   assign clr_go       = 1'b0;
`endif

   // Guests and non-BCD scores never touch the RAM or the top score.
   assign bad_game = isGuest || (scoreTens > 4'd9) || (scoreOnes > 4'd9);

   // State register; reset aborts any operation, including a pending write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Next-state decode and RAM port drive (outputs are pure state decodes).
   always_comb begin
      next_state = state;
      ram_addr   = '0;
      ram_we     = 1'b0;
      ram_wdata  = 8'h00;
      case (state)
         IDLE: begin
            if (clr_go)        next_state = CLR;
            else if (gameOver) next_state = bad_game ? DONE : RD;
         end
         RD: begin
            ram_addr   = uid_q;
            next_state = CMP;
         end
         CMP: next_state = (score_q > ram_rdata) ? WR : TOP;
         WR: begin
            ram_addr   = uid_q;
            ram_we     = 1'b1;
            ram_wdata  = score_q;
            next_state = TOP;
         end
         TOP:  next_state = DONE;
         DONE: next_state = IDLE;
         CLR: begin
            ram_addr = clr_cnt;
            ram_we   = 1'b1;
            if (clr_cnt == '1) next_state = DONE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Request capture, top-score tracking, result flags and clear address counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         uid_q      <= '0;
         score_q    <= 8'h00;
         top_id_q   <= '0;
         top_tens_q <= 4'h0;
         top_ones_q <= 4'h0;
         best_q     <= 1'b0;
         top_q      <= 1'b0;
         clr_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               best_q  <= 1'b0;
               top_q   <= 1'b0;
               clr_cnt <= '0;
               if (!clr_go && gameOver) begin
                  uid_q   <= userID;
                  score_q <= {scoreTens, scoreOnes};
               end
            end
            WR: best_q <= 1'b1;
            TOP: begin
               // Ties keep the existing holder.
               if (score_q > {top_tens_q, top_ones_q}) begin
                  top_tens_q <= score_q[7:4];
                  top_ones_q <= score_q[3:0];
                  top_id_q   <= uid_q;
                  top_q      <= 1'b1;
               end
            end
            DONE: begin
               best_q <= 1'b0;
               top_q  <= 1'b0;
            end
            CLR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == '1) begin
                  top_tens_q <= 4'h0;
                  top_ones_q <= 4'h0;
                  top_id_q   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign topIntID  = top_id_q;
   assign topTens   = top_tens_q;
   assign topOnes   = top_ones_q;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign newBest   = best_q;
   assign newTop    = top_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed table, reset/clear sequences, then random
// games checked against a decimal-arithmetic model of best/top scores.
module tb_score_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       gameOver, isGuest, clearReq;
   logic [2:0] userID;
   logic [3:0] scoreTens, scoreOnes;
   logic [2:0] ram_addr, topIntID;
   logic       ram_we;
   logic [7:0] ram_wdata, ram_rdata;
   logic [3:0] topTens, topOnes;
   logic       busy, done, newBest, newTop;
   logic [2:0] state_dbg;

   int tests = 0;
   int fails = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   score_ctrl #(.ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .gameOver(gameOver), .isGuest(isGuest),
      .userID(userID), .scoreTens(scoreTens), .scoreOnes(scoreOnes),
      .clearReq(clearReq), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .topIntID(topIntID),
      .topTens(topTens), .topOnes(topOnes), .busy(busy), .done(done),
      .newBest(newBest), .newTop(newTop), .state_dbg(state_dbg)
   );

   // ---------------- score RAM with registered read ----------------
   logic [7:0]  mem [8];
   logic [10:0] wr_log[$];
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
         wr_log.push_back({ram_addr, ram_wdata});
      end
      ram_rdata <= mem[ram_addr];
   end

   // ---------------- reference model (decimal scores) ----------------
   int          model_mem [8];
   int          model_top;
   logic [2:0]  model_top_id;
   logic [10:0] exp_q[$];

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   function automatic int to_dec(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   task automatic model_game(input logic guest, input logic [2:0] uid,
                             input logic [3:0] tens, input logic [3:0] ones,
                             output int lat, output logic best, output logic ntop);
      int sc;
      if (guest || tens > 4'd9 || ones > 4'd9) begin
         lat = 1; best = 1'b0; ntop = 1'b0;
      end else begin
         sc   = int'(tens) * 10 + int'(ones);
         best = (sc > model_mem[uid]);
         if (best) begin
            model_mem[uid] = sc;
            exp_q.push_back({uid, tens, ones});
         end
         lat  = best ? 5 : 4;
         ntop = (sc > model_top);
         if (ntop) begin
            model_top    = sc;
            model_top_id = uid;
         end
      end
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_writes(input string tag);
      int n;
      check({tag, "_wr_count"}, wr_log.size(), exp_q.size());
      n = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_wr_addr_data"}, wr_log[i], exp_q[i]);
      wr_log.delete();
      exp_q.delete();
   endtask

   task automatic check_top(input string tag);
      check({tag, "_top_score"}, {topTens, topOnes}, to_bcd(model_top));
      check({tag, "_top_id"}, topIntID, model_top_id);
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_top    = 0;
      model_top_id = 3'd0;
   endtask

   task automatic preload(input logic [2:0] a, input logic [7:0] v);
      mem[a]      = v;
      model_mem[a] = to_dec(v);
   endtask

   // Issues one request; returns the done latency in cycles (0 on timeout)
   // and the flags seen in the done cycle. Optionally re-pulses gameOver
   // while busy, then watches that no extra done appears.
   task automatic run_game(input logic guest, input logic [2:0] uid,
                           input logic [3:0] tens, input logic [3:0] ones,
                           input logic clr, input logic spam,
                           output int lat, output logic best, output logic ntop);
      int extra;
      @(negedge clk);
      isGuest = guest; userID = uid; scoreTens = tens; scoreOnes = ones;
      gameOver = 1'b1; clearReq = clr;
      @(negedge clk);
      gameOver = 1'b0; clearReq = 1'b0; isGuest = 1'b0;
      lat = 0; best = 1'b0; ntop = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         if (done === 1'b1) begin
            lat = k; best = newBest; ntop = newTop;
            break;
         end
         if (spam && k == 2) begin
            gameOver = 1'b1; userID = uid + 3'd1; scoreTens = 4'd9; scoreOnes = 4'd9;
         end
         if (spam && k == 3) gameOver = 1'b0;
         @(negedge clk);
      end
      gameOver = 1'b0;
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      check("extra_done", extra, 0);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic       guest;
      logic [2:0] uid;
      logic [3:0] tens, ones;
      logic       pre_en;
      logic [7:0] pre;
      logic       spam;
      int         lat;
      logic       best, ntop;
      logic [7:0] tscore;
      logic [2:0] tid;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int   lat, m_lat;
      logic best, ntop, m_best, m_ntop;
      int   seen;

      vecs[0] = '{1'b0, 3'd2, 4'd4, 4'd7, 1'b1, 8'h35, 1'b0, 5, 1'b1, 1'b1, 8'h47, 3'd2};
      vecs[1] = '{1'b0, 3'd1, 4'd6, 4'd0, 1'b1, 8'h00, 1'b0, 5, 1'b1, 1'b1, 8'h60, 3'd1};
      vecs[2] = '{1'b0, 3'd5, 4'd6, 4'd0, 1'b1, 8'h60, 1'b0, 4, 1'b0, 1'b0, 8'h60, 3'd1};
      vecs[3] = '{1'b1, 3'd3, 4'd9, 4'd9, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h60, 3'd1};
      vecs[4] = '{1'b0, 3'd4, 4'd9, 4'hA, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h60, 3'd1};
      vecs[5] = '{1'b0, 3'd6, 4'd1, 4'd0, 1'b1, 8'h20, 1'b1, 4, 1'b0, 1'b0, 8'h60, 3'd1};
      vecs[6] = '{1'b0, 3'd7, 4'd3, 4'd0, 1'b1, 8'h05, 1'b0, 5, 1'b1, 1'b0, 8'h60, 3'd1};
      vecs[7] = '{1'b0, 3'd0, 4'd6, 4'd0, 1'b1, 8'h10, 1'b0, 5, 1'b1, 1'b0, 8'h60, 3'd1};
      vecs[8] = '{1'b0, 3'd2, 4'hB, 4'd0, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h60, 3'd1};
      vecs[9] = '{1'b0, 3'd3, 4'd9, 4'd9, 1'b1, 8'h99, 1'b0, 4, 1'b0, 1'b1, 8'h99, 3'd3};

      rst = 1'b0; gameOver = 1'b0; isGuest = 1'b0; clearReq = 1'b0;
      userID = 3'd0; scoreTens = 4'd0; scoreOnes = 4'd0;
      for (int i = 0; i < 8; i++) begin
         mem[i] = 8'h00;
         model_mem[i] = 0;
      end
      model_top = 0; model_top_id = 3'd0;

      // Reset values.
      #12;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_we", ram_we, 1'b0);
      check("rst_addr", ram_addr, 3'd0);
      check("rst_flags", {newBest, newTop}, 2'b00);
      check("rst_top", {topIntID, topTens, topOnes}, 11'd0);
      check("rst_state", state_dbg, 3'd0);
      do_reset();

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].pre_en) preload(vecs[i].uid, vecs[i].pre);
         model_game(vecs[i].guest, vecs[i].uid, vecs[i].tens, vecs[i].ones, m_lat, m_best, m_ntop);
         run_game(vecs[i].guest, vecs[i].uid, vecs[i].tens, vecs[i].ones, 1'b0, vecs[i].spam,
                  lat, best, ntop);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_newBest", i), best, vecs[i].best);
         check($sformatf("vec%0d_newTop", i), ntop, vecs[i].ntop);
         check($sformatf("vec%0d_top_score", i), {topTens, topOnes}, vecs[i].tscore);
         check($sformatf("vec%0d_top_id", i), topIntID, vecs[i].tid);
         check_writes($sformatf("vec%0d", i));
      end

      // Reset in the middle of the write cycle: write must not happen.
      preload(3'd4, 8'h00);
      wr_log.delete();
      @(negedge clk);
      userID = 3'd4; scoreTens = 4'd5; scoreOnes = 4'd5; gameOver = 1'b1;
      @(negedge clk);
      gameOver = 1'b0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         if (ram_we === 1'b1) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      check("wr_reached", seen, 1);
      rst = 1'b0;
      #1;
      check("midrst_we", ram_we, 1'b0);
      check("midrst_addr_data", {ram_addr, ram_wdata}, 11'd0);
      check("midrst_busy_done", {busy, done}, 2'b00);
      check("midrst_flags", {newBest, newTop}, 2'b00);
      check("midrst_top", {topIntID, topTens, topOnes}, 11'd0);
      check("midrst_state", state_dbg, 3'd0);
      @(negedge clk);
      rst = 1'b1;
      model_top = 0; model_top_id = 3'd0;
      check("midrst_ram_kept", mem[4], 8'h00);
      check("midrst_no_write", wr_log.size(), 0);
      wr_log.delete();

`ifdef SCORE_CLEAR_EN
      // Clear with a simultaneous gameOver: clear wins, every slot zeroed.
      for (int i = 0; i < 8; i++) preload(3'(i), 8'h11 * 8'(i + 1));
      run_game(1'b0, 3'd2, 4'd9, 4'd9, 1'b1, 1'b0, lat, best, ntop);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({3'(i), 8'h00});
         model_mem[i] = 0;
      end
      model_top = 0; model_top_id = 3'd0;
      check("clr_latency", lat, 9);
      check("clr_flags", {best, ntop}, 2'b00);
      check_top("clr");
      check_writes("clr");
`else
      // clearReq alone does nothing; with gameOver the game runs normally.
      @(negedge clk);
      clearReq = 1'b1;
      @(negedge clk);
      check("clr_ignored_busy", busy, 1'b0);
      clearReq = 1'b0;
      model_game(1'b0, 3'd2, 4'd9, 4'd9, m_lat, m_best, m_ntop);
      run_game(1'b0, 3'd2, 4'd9, 4'd9, 1'b1, 1'b0, lat, best, ntop);
      check("clr_off_latency", lat, m_lat);
      check("clr_off_flags", {best, ntop}, {m_best, m_ntop});
      check_top("clr_off");
      check_writes("clr_off");
`endif

      // Random games against the model, with periodic resets.
      for (int g = 0; g < 40; g++) begin
         logic       r_guest, r_spam;
         logic [2:0] r_uid;
         logic [3:0] r_t, r_o;
         if (g % 10 == 0) do_reset();
         r_guest = ($urandom_range(0, 7) == 0);
         r_uid   = 3'($urandom_range(0, 7));
         r_t     = 4'($urandom_range(0, 10));
         r_o     = 4'($urandom_range(0, 10));
         r_spam  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0)
            preload(r_uid, to_bcd($urandom_range(0, 99)));
         model_game(r_guest, r_uid, r_t, r_o, m_lat, m_best, m_ntop);
         run_game(r_guest, r_uid, r_t, r_o, 1'b0, r_spam, lat, best, ntop);
         check("rnd_latency", lat, m_lat);
         check("rnd_flags", {best, ntop}, {m_best, m_ntop});
         check_top("rnd");
         check_writes("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 3, user-ID and score-RAM address width (2**ADDR_W user slots).
REQ-002 SHALL have port: clk  in  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: gameOver  in  1  single-cycle start pulse, end of a game.
REQ-005 SHALL have port: isGuest  in  1  player is guest, sampled with gameOver.
REQ-006 SHALL have port: userID  in  ADDR_W  player internal ID, sampled with gameOver.
REQ-007 SHALL have ports: scoreTens, scoreOnes  in  4 each  final BCD score, sampled with gameOver.
REQ-008 SHALL have port: clearReq  in  1  clear-all request, level-sampled in IDLE.
REQ-009 SHALL have ports: ram_addr out ADDR_W; ram_we out 1; ram_wdata out 8 {tens,ones}; ram_rdata in 8, score RAM with registered read (data valid cycle after address).
REQ-010 SHALL have ports: topIntID out ADDR_W (drives UID_ROM address); topTens, topOnes out 4 each, current top score.
REQ-011 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); newBest out 1; newTop out 1 (valid while done=1).

Function
REQ-012 SHALL implement FSM states IDLE, RD, CMP, WR, TOP, DONE, CLR.
REQ-013 IDLE: on gameOver=1 SHALL latch isGuest, userID, score; go DONE if isGuest=1 or any digit >9, else RD.
REQ-014 RD: SHALL drive ram_addr=latched userID, ram_we=0; next state CMP.
REQ-015 CMP: SHALL compare latched {tens,ones} against ram_rdata as unsigned 8-bit; strictly greater -> WR, else TOP.
REQ-016 WR: SHALL assert ram_we=1 for exactly one cycle with ram_addr=userID, ram_wdata={tens,ones}; set newBest; next TOP.
REQ-017 TOP: score strictly greater than {topTens,topOnes} SHALL load top score and topIntID=userID and set newTop; next DONE.
REQ-018 DONE: SHALL pulse done=1 for one cycle with newBest/newTop valid; next IDLE; newBest/newTop cleared on leaving DONE.
REQ-019 Ties SHALL NOT count as new best or new top; guest and invalid-BCD runs SHALL finish with newBest=newTop=0 and no RAM write.
REQ-020 Latency: done SHALL rise 4 cycles after the gameOver sampling edge (no write) or 5 cycles (with write); guest/invalid: 1 cycle.
REQ-021 busy SHALL be 1 in every state except IDLE; gameOver or clearReq while busy SHALL be ignored, not queued.
REQ-022 ram_we SHALL be 0 in all states except WR and CLR.

Reset
REQ-023 rst=0 SHALL immediately force IDLE and outputs ram_addr=0, ram_we=0, ram_wdata=0, topIntID=0, topTens=topOnes=0, busy=0, done=0, newBest=newTop=0.
REQ-024 Reset mid-operation SHALL abort without completing any pending write; RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-025 Macro SCORE_CLEAR_EN defined: clearReq=1 in IDLE SHALL enter CLR (priority over simultaneous gameOver), writing 8'h00 to addresses 0..2**ADDR_W-1 one per cycle with ram_we=1, then zero top score and topIntID, then DONE with flags 0.
REQ-026 Macro SCORE_CLEAR_EN undefined: clearReq port SHALL remain present and be ignored; CLR state unreachable.

Verification
REQ-027 RAM[2]=8'h35, gameOver with userID=2, score 4/7 -> one write addr 2 data 8'h47, done at cycle 5, newBest=1, newTop=1, topIntID=2.
REQ-028 RAM[5]=8'h60, score 6/0, top=8'h60 -> no write, done at cycle 4, newBest=0, newTop=0.
REQ-029 isGuest=1 score 9/9 -> no RAM access, done next cycle, flags 0, top unchanged.
REQ-030 scoreOnes=4'hA -> done next cycle, no write, flags 0; gameOver pulse during busy -> ignored, exactly one done.
REQ-031 rst low during WR cycle -> ram_we falls immediately, all outputs at reset values, FSM IDLE.
REQ-032 SCORE_CLEAR_EN, clearReq and gameOver same cycle -> 8 writes of 8'h00 at addr 0..7, top=0, done, gameOver ignored.
